sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 8: number of adder results summed per frame (legal 2..16).
REQ-002 Parameter ACC_W, default 8: accumulator width (legal 6..16).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: begin a frame; honoured only in IDLE.
REQ-006 Port clr, input, 1: abort and zero; honoured in any state.
REQ-007 Port in_valid, input, 1: upstream adder result present.
REQ-008 Port sum, input, 4: adder 4-bit sum.
REQ-009 Port cout, input, 1: adder carry out; operand value is {cout,sum}, 0..31.
REQ-010 Port in_ready, output, 1: block accepts an operand this cycle.
REQ-011 Port acc, output, ACC_W: running or final total.
REQ-012 Port cnt, output, 5: operands accepted in current frame.
REQ-013 Port out_valid, output, 1: frame total valid on acc.
REQ-014 Port out_ready, input, 1: downstream consumes total.
REQ-015 Port ovf, output, 1: sticky overflow for current frame.

Function
REQ-016 States IDLE, ACCUM, DONE; IDLE->ACCUM on start; ACCUM->DONE on the N_SAMPLES-th transfer; DONE->IDLE on out_ready.
REQ-017 in_ready = 1 only in ACCUM; combinational from state, not from in_valid.
REQ-018 Transfer = in_valid & in_ready; on transfer acc += {cout,sum} zero-extended, cnt += 1, same edge.
REQ-019 No transfer in IDLE or DONE; in_valid there is ignored, acc unchanged.
REQ-020 out_valid = 1 exactly in DONE, registered; first asserted the cycle after the final transfer.
REQ-021 acc, cnt, ovf held stable throughout DONE until out_ready.
REQ-022 DONE->IDLE edge clears acc, cnt, ovf to 0.
REQ-023 start in IDLE on same edge also clears acc, cnt, ovf.
REQ-024 start outside IDLE ignored.
REQ-025 clr has priority over start, transfer and out_ready: next state IDLE, acc/cnt/ovf = 0.
REQ-026 Overflow: carry out of ACC_W bits in any transfer sets ovf; ovf stays set until cleared per REQ-022/023/025.
REQ-027 Latency: final total visible on acc/out_valid one cycle after last transfer; back-to-back transfers sustain one per cycle.

Reset
REQ-028 rst overrides all inputs including clr: state IDLE, acc 0, cnt 0, ovf 0, out_valid 0, in_ready 0.
REQ-029 rst mid-frame discards partial total; no out_valid is produced for that frame.

Configuration
REQ-030 Macro ACC_SAT_EN defined: on overflow acc saturates to all-ones (2^ACC_W-1) and holds there for the frame; ovf set.
REQ-031 ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W; ovf set.

Structure
REQ-032 Package acc_pkg holds the state typedef (IDLE, ACCUM, DONE), operand width constant OPND_W = 5, and count width constant CNT_W = 5.
REQ-033 One sub-module acc_datapath: adder, overflow detect, saturate/wrap mux; FSM remains in sum_accumulator.

Verification
REQ-034 Defaults; start, feed 3,5,7,9,0,0,0,0 (one per cycle) -> cnt 8, acc 24, out_valid next cycle, ovf 0.
REQ-035 Defaults; feed eight 31s (cout=1, sum=15) -> acc 248, ovf 0.
REQ-036 N_SAMPLES=16; feed sixteen 31s -> ACC_SAT_EN undefined: acc 240, ovf 1; defined: acc 255, ovf 1.
REQ-037 In DONE, hold out_ready=0 for 5 cycles with in_valid=1 -> acc, cnt, out_valid unchanged; in_ready 0; out_ready=1 -> IDLE, acc 0.
REQ-038 After 3 transfers, assert clr together with in_valid -> next cycle IDLE, acc 0, cnt 0; assert rst mid-frame -> same, out_valid never pulses.
REQ-039 in_valid toggling every other cycle, 8 operands of 2 -> acc 16 after 15 cycles in ACCUM.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and widths for the frame-summing accumulator.
// Used by sum_accumulator and acc_datapath.
package acc_pkg;

    localparam int OPND_W = 5;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_datapath.sv
// Adder, overflow detect and saturate/wrap select for the accumulator.
// Macro ACC_SAT_EN selects saturation; otherwise the total wraps.
module acc_datapath
    import acc_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [OPND_W-1:0] i_opnd,
    input  logic              i_ovf,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_ovf
);

    logic [ACC_W:0] w_sum;
    logic           w_carry;

    // Widened add so the carry out of the top bit is visible.
    always_comb begin
        w_sum   = {1'b0, i_acc} + (ACC_W+1)'(i_opnd);
        w_carry = w_sum[ACC_W];
    end

    // Next total and sticky overflow flag.
    always_comb begin
        o_ovf = i_ovf | w_carry;
`ifdef ACC_SAT_EN
        // Once the frame has overflowed the total pins at all-ones.
        o_acc = o_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        o_acc = w_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES adder results per frame with a valid/ready handshake.
// Optional macro ACC_SAT_EN: saturate instead of wrap on overflow.
module sum_accumulator
    import acc_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       sum,
    input  logic             cout,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_xfer;
    logic             w_last;
    logic             w_zero;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    acc_datapath #(
        .ACC_W (ACC_W)
    ) u_dp (
        .i_acc  (r_acc),
        .i_opnd ({cout, sum}),
        .i_ovf  (r_ovf),
        .o_acc  (w_acc_nxt),
        .o_ovf  (w_ovf_nxt)
    );

    // Next state, handshake and frame-clear decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        w_zero      = 1'b0;
        if (r_state == ACCUM) begin
            w_in_ready = 1'b1;
        end
        w_xfer = in_valid & w_in_ready;
        w_last = w_xfer && (r_cnt == CNT_W'(N_SAMPLES - 1));
        if (clr) begin
            w_state_nxt = IDLE;
            w_zero      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = ACCUM;
                        w_zero      = 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                        w_zero      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_zero      = 1'b1;
                end
            endcase
        end
    end

    // State register; out_valid registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Running total, operand count and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst || w_zero) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign acc       = r_acc;
    assign cnt       = r_cnt;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (default and N_SAMPLES=16).
// Scoreboard holds expected frame totals for the default instance.
module tb_sum_accumulator;
    import acc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       cout = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready;
    logic [7:0] acc;
    logic [4:0] cnt;
    logic       out_valid;
    logic       ovf;

    logic       in_ready16;
    logic [7:0] acc16;
    logic [4:0] cnt16;
    logic       out_valid16;
    logic       ovf16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] acc;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    sum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .in_ready  (in_ready),
        .acc       (acc),
        .cnt       (cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    sum_accumulator #(.N_SAMPLES(16), .ACC_W(8)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .in_ready  (in_ready16),
        .acc       (acc16),
        .cnt       (cnt16),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .ovf       (ovf16)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int total, input int n);
        exp_t e;
        e.ovf = (total > 255);
`ifdef ACC_SAT_EN
        e.acc = e.ovf ? 8'hFF : 8'(total);
`else
        e.acc = 8'(total);
`endif
        e.cnt = 5'(n);
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int v);
        in_valid = 1'b1;
        {cout, sum} = 5'(v);
    endtask

    task automatic do_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ready;
        out_ready = 1'b1;
        tick();
        out_ready = 0;
    endtask

    // Drives operands one per cycle (or with idle gaps); pushes the
    // default instance's expected total when its 8th operand goes out.
    task automatic run_frame(input int ops[$], input bit gaps);
        int total = 0;
        for (int k = 0; k < ops.size(); k++) begin
            drive_op(ops[k]);
            total += ops[k];
            if (k == 7) sb.push_back(model(total, 8));
            tick();
            if (gaps && k < ops.size() - 1) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid and pops the next expectation.
    task automatic wait_pop(output bit ok, output exp_t e);
        ok = 1'b0;
        e.acc = '0;
        e.cnt = '0;
        e.ovf = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (sb.size() == 0) ok = 1'b0;
        else e = sb.pop_front();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clr = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        drive_op(31);
        tick();
        tick();
        checks++;
        if ({acc, cnt, ovf, out_valid, in_ready} !== 16'd0) begin
            failures++;
            $display("FAIL reset acc=%0d cnt=%0d ovf=%0b ov=%0b ir=%0b want all 0",
                     acc, cnt, ovf, out_valid, in_ready);
        end
        rst = 1'b0;
        clr = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || acc !== 8'd0) begin
            failures++;
            $display("FAIL reset_idle ir=%0b acc=%0d want 0 0", in_ready, acc);
        end
    endtask

    task automatic test_basic;
        int q[$];
        bit ok;
        exp_t e;
        int early;
        q = {3, 5, 7, 9, 0, 0, 0, 0};
        do_clr();
        do_start();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accum_ready got=%0b want=1", in_ready);
        end
        early = 0;
        for (int k = 0; k < 8; k++) begin
            drive_op(q[k]);
            if (k == 7) sb.push_back(model(24, 8));
            tick();
            if (k < 7 && out_valid !== 1'b0) early++;
        end
        in_valid = 1'b0;
        checks++;
        if (early != 0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency early=%0d ov=%0b want 0 1", early, out_valid);
        end
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || ovf !== e.ovf
            || e.acc !== 8'd24) begin
            failures++;
            $display("FAIL basic_frame acc=%0d cnt=%0d ovf=%0b want %0d %0d %0b",
                     acc, cnt, ovf, e.acc, e.cnt, e.ovf);
        end
        pulse_ready();
        checks++;
        if (out_valid !== 1'b0 || acc !== 8'd0 || cnt !== 5'd0) begin
            failures++;
            $display("FAIL basic_release ov=%0b acc=%0d cnt=%0d want 0 0 0",
                     out_valid, acc, cnt);
        end
    endtask

    task automatic test_max;
        int q[$];
        bit ok;
        exp_t e;
        q = {31, 31, 31, 31, 31, 31, 31, 31};
        do_clr();
        do_start();
        start = 1'b1;
        run_frame(q, 1'b0);
        start = 1'b0;
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || ovf !== e.ovf) begin
            failures++;
            $display("FAIL max_frame acc=%0d cnt=%0d ovf=%0b want %0d %0d %0b",
                     acc, cnt, ovf, e.acc, e.cnt, e.ovf);
        end
        pulse_ready();
    endtask

    task automatic test_sat;
        int q[$];
        bit ok;
        exp_t e;
        exp_t e16;
        q = {};
        for (int k = 0; k < 16; k++) q.push_back(31);
        e16 = model(16 * 31, 16);
        do_clr();
        do_start();
        run_frame(q, 1'b0);
        checks++;
        if (out_valid16 !== 1'b1 || acc16 !== e16.acc || ovf16 !== 1'b1
            || cnt16 !== e16.cnt) begin
            failures++;
            $display("FAIL n16_overflow ov=%0b acc=%0d cnt=%0d ovf=%0b want 1 %0d %0d 1",
                     out_valid16, acc16, cnt16, ovf16, e16.acc, e16.cnt);
        end
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || ovf !== e.ovf) begin
            failures++;
            $display("FAIL n8_in_n16_run acc=%0d cnt=%0d ovf=%0b want %0d %0d %0b",
                     acc, cnt, ovf, e.acc, e.cnt, e.ovf);
        end
        pulse_ready();
        checks++;
        if (out_valid16 !== 1'b0 || acc16 !== 8'd0 || ovf16 !== 1'b0) begin
            failures++;
            $display("FAIL n16_release ov=%0b acc=%0d ovf=%0b want 0 0 0",
                     out_valid16, acc16, ovf16);
        end
    endtask

    task automatic test_hold;
        int q[$];
        bit ok;
        exp_t e;
        int bad;
        q = {1, 2, 3, 4, 5, 6, 7, 8};
        do_clr();
        do_start();
        run_frame(q, 1'b0);
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || e.acc !== 8'd36) begin
            failures++;
            $display("FAIL hold_frame acc=%0d cnt=%0d want %0d %0d",
                     acc, cnt, e.acc, e.cnt);
        end
        drive_op(31);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc !== e.acc || cnt !== e.cnt || out_valid !== 1'b1
                || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL done_hold bad_cycles=%0d acc=%0d cnt=%0d ov=%0b ir=%0b want 0",
                     bad, acc, cnt, out_valid, in_ready);
        end
        in_valid = 1'b0;
        pulse_ready();
        checks++;
        if (acc !== 8'd0 || cnt !== 5'd0 || out_valid !== 1'b0
            || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_exit acc=%0d cnt=%0d ov=%0b ir=%0b want 0 0 0 0",
                     acc, cnt, out_valid, in_ready);
        end
    endtask

    task automatic test_clr_rst;
        int q[$];
        int seen;
        q = {4, 5, 6};
        do_clr();
        do_start();
        run_frame(q, 1'b0);
        checks++;
        if (acc !== 8'd15 || cnt !== 5'd3 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL partial acc=%0d cnt=%0d ov=%0b want 15 3 0",
                     acc, cnt, out_valid);
        end
        drive_op(7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (acc !== 8'd0 || cnt !== 5'd0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_abort acc=%0d cnt=%0d ir=%0b ovf=%0b want 0 0 0 0",
                     acc, cnt, in_ready, ovf);
        end
        do_start();
        run_frame(q, 1'b0);
        rst = 1'b1;
        drive_op(7);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        checks++;
        if (seen != 0 || acc !== 8'd0 || cnt !== 5'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort ov_cycles=%0d acc=%0d cnt=%0d ir=%0b want 0 0 0 0",
                     seen, acc, cnt, in_ready);
        end
    endtask

    task automatic test_toggle;
        int q[$];
        bit ok;
        exp_t e;
        q = {2, 2, 2, 2, 2, 2, 2, 2};
        do_clr();
        do_start();
        run_frame(q, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || acc !== 8'd16) begin
            failures++;
            $display("FAIL toggle_15cyc ov=%0b acc=%0d want 1 16", out_valid, acc);
        end
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || ovf !== e.ovf) begin
            failures++;
            $display("FAIL toggle_frame acc=%0d cnt=%0d ovf=%0b want %0d %0d %0b",
                     acc, cnt, ovf, e.acc, e.cnt, e.ovf);
        end
        pulse_ready();
    endtask

    task automatic test_back_to_back;
        int q1[$];
        int q2[$];
        bit ok;
        exp_t e;
        q1 = {1, 1, 1, 1, 1, 1, 1, 1};
        q2 = {10, 20, 30, 1, 2, 3, 4, 5};
        do_clr();
        do_start();
        run_frame(q1, 1'b0);
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt) begin
            failures++;
            $display("FAIL b2b_first acc=%0d cnt=%0d want %0d %0d",
                     acc, cnt, e.acc, e.cnt);
        end
        pulse_ready();
        do_start();
        run_frame(q2, 1'b0);
        wait_pop(ok, e);
        checks++;
        if (!ok || acc !== e.acc || cnt !== e.cnt || e.acc !== 8'd75) begin
            failures++;
            $display("FAIL b2b_second acc=%0d cnt=%0d want %0d %0d",
                     acc, cnt, e.acc, e.cnt);
        end
        pulse_ready();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_sat();
        test_hold();
        test_clr_rst();
        test_toggle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
